// File: rtl/rca_operand_loader.sv
// Streams two WIDTH-bit operands in as CHUNK-bit pieces, drives an external adder and
// returns its sum over valid/ready. Optional result self-check: RCA_SELF_CHECK_EN.
module rca_operand_loader #(
  parameter int WIDTH     = 64,
  parameter int CHUNK     = 16,
  parameter int ADDER_LAT = 1
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [CHUNK-1:0] chunk_pi,
  input  logic             chunk_valid_pi,
  output logic             chunk_ready_po,
  input  logic             abort_pi,
  output logic [WIDTH-1:0] A_po,
  output logic [WIDTH-1:0] B_po,
  input  logic [WIDTH-1:0] result_pi,
  output logic [WIDTH-1:0] sum_po,
  output logic             sum_valid_po,
  input  logic             sum_ready_pi,
  output logic             busy_po,
  output logic             mismatch_po
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WCW  = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WCW-1:0]   r_wcnt;
  logic [WIDTH-1:0] r_asm_a;
  logic [WIDTH-1:0] r_asm_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_sum_valid;

  logic [WIDTH-1:0] w_asm_a_next;
  logic [WIDTH-1:0] w_asm_b_next;
  logic             w_capture;

  // Assembly registers with the incoming chunk merged at the current index, so the
  // final B chunk can reach B_po on the same edge it is accepted.
  always_comb begin
    w_asm_a_next = r_asm_a;
    w_asm_b_next = r_asm_b;
    w_asm_a_next[r_idx*CHUNK +: CHUNK] = chunk_pi;
    w_asm_b_next[r_idx*CHUNK +: CHUNK] = chunk_pi;
  end

  assign w_capture = (r_state == WAIT) && (r_wcnt == '0);

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_asm_a     <= '0;
      r_asm_b     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (abort_pi) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_asm_a     <= '0;
      r_asm_b     <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: if (chunk_valid_pi) begin
          r_asm_a <= w_asm_a_next;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= LOAD_B;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        LOAD_B: if (chunk_valid_pi) begin
          r_asm_b <= w_asm_b_next;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_a     <= r_asm_a;
            r_b     <= w_asm_b_next;
            r_wcnt  <= WCW'(ADDER_LAT);
            r_state <= WAIT;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        WAIT: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - WCW'(1);
          end else begin
            r_sum       <= result_pi;
            r_sum_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: if (r_sum_valid && sum_ready_pi) begin
          r_sum_valid <= 1'b0;
          r_state     <= LOAD_A;
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

`ifdef RCA_SELF_CHECK_EN
  logic [WIDTH-1:0] w_ref;
  logic             r_mismatch;

  assign w_ref = r_a + r_b;

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      r_mismatch <= 1'b0;
    end else if (abort_pi) begin
      r_mismatch <= 1'b0;
    end else if (w_capture && (result_pi != w_ref)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch_po = r_mismatch;
`else
  assign mismatch_po = 1'b0;
`endif

  assign chunk_ready_po = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign busy_po        = (r_state != LOAD_A) || (r_idx != '0);
  assign A_po           = r_a;
  assign B_po           = r_b;
  assign sum_po         = r_sum;
  assign sum_valid_po   = r_sum_valid;

endmodule

// File: tb/tb_rca_operand_loader.sv
// Directed bench for rca_operand_loader with a one-stage registered adder model
// (optional +1 error injection on the adder output).
module tb_rca_operand_loader;

  logic        clk_pi = 1'b0;
  logic        rst_pi;
  logic [15:0] chunk_pi;
  logic        chunk_valid_pi;
  logic        chunk_ready_po;
  logic        abort_pi;
  logic [63:0] A_po, B_po, result_pi, sum_po;
  logic        sum_valid_po, sum_ready_pi, busy_po, mismatch_po;
  logic [63:0] err_inj;

  int errors = 0;
  int checks = 0;

`ifdef RCA_SELF_CHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  rca_operand_loader #(.WIDTH(64), .CHUNK(16), .ADDER_LAT(1)) dut (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .chunk_pi(chunk_pi), .chunk_valid_pi(chunk_valid_pi),
    .chunk_ready_po(chunk_ready_po), .abort_pi(abort_pi), .A_po(A_po), .B_po(B_po),
    .result_pi(result_pi), .sum_po(sum_po), .sum_valid_po(sum_valid_po),
    .sum_ready_pi(sum_ready_pi), .busy_po(busy_po), .mismatch_po(mismatch_po)
  );

  always #5 clk_pi = ~clk_pi;

  // One register stage between operands and result, matching ADDER_LAT=1
  always @(posedge clk_pi) result_pi <= A_po + B_po + err_inj;

  task automatic push(input logic [15:0] d, input bit gap);
    int n;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk_pi);
    chunk_pi = d;
    chunk_valid_pi = 1'b1;
    n = 0;
    while (!chunk_ready_po && n < 50) begin
      @(negedge clk_pi);
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL chunk_accept: chunk_ready_po=%0b after %0d cycles, required 1", chunk_ready_po, n);
    end
    @(negedge clk_pi);
    chunk_valid_pi = 1'b0;
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit gap,
                       output logic [63:0] s, output bit to);
    int n;
    for (int unsigned k = 0; k < 4; k++) push(a[k*16 +: 16], gap);
    for (int unsigned k = 0; k < 4; k++) push(b[k*16 +: 16], gap);
    n = 0;
    while (!sum_valid_po && n < 20) begin
      @(negedge clk_pi);
      n++;
    end
    to = !sum_valid_po;
    s  = sum_po;
  endtask

  task automatic accept();
    sum_ready_pi = 1'b1;
    @(negedge clk_pi);
    sum_ready_pi = 1'b0;
  endtask

  task automatic test_reset();
    rst_pi = 1'b1;
    repeat (3) @(posedge clk_pi);
    @(negedge clk_pi);
    rst_pi = 1'b0;
    @(negedge clk_pi);
    checks++; if (sum_po !== 64'h0) begin errors++; $display("FAIL rst_sum: got %h want 0", sum_po); end
    checks++; if (sum_valid_po !== 1'b0) begin errors++; $display("FAIL rst_sum_valid: got %b want 0", sum_valid_po); end
    checks++; if (busy_po !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_po); end
    checks++; if (chunk_ready_po !== 1'b1) begin errors++; $display("FAIL rst_chunk_ready: got %b want 1", chunk_ready_po); end
    checks++; if (A_po !== 64'h0 || B_po !== 64'h0) begin errors++; $display("FAIL rst_operands: got A=%h B=%h want 0", A_po, B_po); end
    checks++; if (mismatch_po !== 1'b0) begin errors++; $display("FAIL rst_mismatch: got %b want 0", mismatch_po); end
  endtask

  task automatic test_basic();
    push(16'h0001, 0);
    checks++; if (busy_po !== 1'b1) begin errors++; $display("FAIL busy_mid_load: got %b want 1", busy_po); end
    for (int unsigned k = 1; k < 4; k++) push(16'h0000, 0);
    push(16'h0002, 0);
    for (int unsigned k = 1; k < 4; k++) push(16'h0000, 0);
    checks++; if (A_po !== 64'd1 || B_po !== 64'd2) begin errors++; $display("FAIL basic_operands: got A=%h B=%h want 1 2", A_po, B_po); end
    checks++; if (sum_valid_po !== 1'b0) begin errors++; $display("FAIL basic_early_valid0: got %b want 0", sum_valid_po); end
    checks++; if (chunk_ready_po !== 1'b0) begin errors++; $display("FAIL basic_wait_ready: got %b want 0", chunk_ready_po); end
    @(negedge clk_pi);
    checks++; if (sum_valid_po !== 1'b0) begin errors++; $display("FAIL basic_early_valid1: got %b want 0", sum_valid_po); end
    @(negedge clk_pi);
    checks++; if (sum_valid_po !== 1'b1 || sum_po !== 64'd3) begin errors++; $display("FAIL basic_capture: got valid=%b sum=%h want 1 3", sum_valid_po, sum_po); end
    accept();
    checks++; if (sum_valid_po !== 1'b0 || busy_po !== 1'b0 || chunk_ready_po !== 1'b1) begin
      errors++; $display("FAIL basic_handshake: got valid=%b busy=%b ready=%b want 0 0 1", sum_valid_po, busy_po, chunk_ready_po);
    end
  endtask

  task automatic test_arith();
    logic [63:0] s; bit to;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, s, to);
    checks++; if (to || s !== 64'h0) begin errors++; $display("FAIL wrap_sum: got %h timeout=%0b want 0", s, to); end
    accept();
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, s, to);
    checks++; if (to || s !== 64'h2222_2222_2222_2211) begin errors++; $display("FAIL pattern_sum: got %h timeout=%0b want 2222222222222211", s, to); end
    accept();
  endtask

  task automatic test_hold_backpressure();
    logic [63:0] s; bit to;
    do_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1, s, to);
    checks++; if (to || s !== 64'h0000_0001_0001_0000) begin errors++; $display("FAIL gap_sum: got %h timeout=%0b want 0000000100010000", s, to); end
    chunk_pi = 16'hFFFF;
    chunk_valid_pi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pi);
      checks++; if (sum_valid_po !== 1'b1 || sum_po !== 64'h0000_0001_0001_0000 || chunk_ready_po !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: got valid=%b sum=%h ready=%b want 1 0000000100010000 0", i, sum_valid_po, sum_po, chunk_ready_po);
      end
    end
    chunk_valid_pi = 1'b0;
    accept();
    do_op(64'd3, 64'd4, 0, s, to);
    checks++; if (to || s !== 64'd7 || A_po !== 64'd3) begin errors++; $display("FAIL post_hold_op: got sum=%h A=%h timeout=%0b want 7 3", s, A_po, to); end
    accept();
  endtask

  task automatic test_abort();
    logic [63:0] s; bit to;
    push(16'hAAAA, 0);
    push(16'hAAAA, 0);
    abort_pi = 1'b1;
    chunk_pi = 16'h5555;
    chunk_valid_pi = 1'b1;
    @(negedge clk_pi);
    abort_pi = 1'b0;
    chunk_valid_pi = 1'b0;
    checks++; if (busy_po !== 1'b0 || A_po !== 64'd3) begin errors++; $display("FAIL abort_load: got busy=%b A=%h want 0 3", busy_po, A_po); end
    do_op(64'h11, 64'h22, 0, s, to);
    checks++; if (to || s !== 64'h33 || A_po !== 64'h11) begin errors++; $display("FAIL abort_fresh_op: got sum=%h A=%h timeout=%0b want 33 11", s, A_po, to); end
    abort_pi = 1'b1;
    @(negedge clk_pi);
    abort_pi = 1'b0;
    checks++; if (sum_valid_po !== 1'b0 || sum_po !== 64'h33 || busy_po !== 1'b0 || chunk_ready_po !== 1'b1) begin
      errors++; $display("FAIL abort_hold: got valid=%b sum=%h busy=%b ready=%b want 0 33 0 1", sum_valid_po, sum_po, busy_po, chunk_ready_po);
    end
  endtask

  task automatic test_self_check();
    logic [63:0] s; bit to;
    err_inj = 64'd1;
    do_op(64'd5, 64'd6, 0, s, to);
    checks++; if (to || s !== 64'd12) begin errors++; $display("FAIL bad_adder_sum: got %h timeout=%0b want c", s, to); end
    checks++; if (mismatch_po !== SC) begin errors++; $display("FAIL mismatch_set: got %b want %b", mismatch_po, SC); end
    accept();
    err_inj = 64'd0;
    do_op(64'd7, 64'd8, 0, s, to);
    checks++; if (to || s !== 64'd15 || mismatch_po !== SC) begin errors++; $display("FAIL mismatch_sticky: got sum=%h mm=%b want f %b", s, mismatch_po, SC); end
    accept();
    abort_pi = 1'b1;
    @(negedge clk_pi);
    abort_pi = 1'b0;
    checks++; if (mismatch_po !== 1'b0) begin errors++; $display("FAIL mismatch_clear: got %b want 0", mismatch_po); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] s; bit to;
    push(16'h1111, 0);
    push(16'h2222, 0);
    push(16'h3333, 0);
    #2 rst_pi = 1'b1;
    #1;
    checks++; if (busy_po !== 1'b0 || A_po !== 64'h0 || B_po !== 64'h0 || sum_valid_po !== 1'b0 || sum_po !== 64'h0) begin
      errors++; $display("FAIL reset_mid: got busy=%b A=%h B=%h valid=%b sum=%h want all 0", busy_po, A_po, B_po, sum_valid_po, sum_po);
    end
    @(negedge clk_pi);
    rst_pi = 1'b0;
    do_op(64'd9, 64'd10, 0, s, to);
    checks++; if (to || s !== 64'd19) begin errors++; $display("FAIL reset_mid_recover: got %h timeout=%0b want 13", s, to); end
    accept();
  endtask

  initial begin
    rst_pi = 1'b1;
    chunk_pi = '0;
    chunk_valid_pi = 1'b0;
    abort_pi = 1'b0;
    sum_ready_pi = 1'b0;
    err_inj = '0;
    test_reset();
    test_basic();
    test_arith();
    test_hold_backpressure();
    test_abort();
    test_self_check();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
